// File: rtl/lab3_qs_timer_ctrl.sv
// lab3_qs_timer_ctrl
// Avalon-MM master that programs an interval-timer slave, acknowledges its
// timeouts, reads counter snapshots and stops it on request. Every bus
// output and status output is driven straight from a register.
module lab3_qs_timer_ctrl #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        snap_req,
  input  logic [31:0] period_in,
  input  logic        irq_in,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  // Timer slave register map, 16-bit words
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control word bits: ITO | CONT | START to run, STOP to halt
  localparam logic [15:0] CTRL_RUN     = 16'h0007;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;
  // Writing anything to status clears TO; writing snap_l latches the counter
  localparam logic [15:0] WORD_ZERO    = 16'h0000;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_PL   = 4'd1,
    S_WR_PH   = 4'd2,
    S_WR_CTRL = 4'd3,
    S_RUN     = 4'd4,
    S_ACK     = 4'd5,
    S_SETTLE  = 4'd6,
    S_SNAP_WR = 4'd7,
    S_RD_SL   = 4'd8,
    S_RD_SH   = 4'd9,
    S_WR_STOP = 4'd10
  } state_t;

  state_t      r_state;
  logic [31:0] r_period;
  logic [31:0] r_tick_count;
  logic [31:0] r_snapshot;
  logic [15:0] r_snap_lo;
  logic [15:0] r_writedata;
  logic [2:0]  r_address;
  logic        r_read;
  logic        r_write;
  logic        r_busy;
  logic        r_tick;
  logic        r_snap_valid;
  logic        r_stop_pending;

  logic [31:0] w_start_period;
  logic        w_xfer_done;
  logic        w_stop_req;

  // A zero period selects the build-time default
  assign w_start_period = (period_in == 32'd0) ? DEFAULT_PERIOD : period_in;
  // The transfer currently presented completes in any cycle without waitrequest
  assign w_xfer_done    = ~avm_waitrequest;
  // A stop arriving in the same cycle as RUN decides is honoured immediately
  assign w_stop_req     = stop | r_stop_pending;

  // Main controller: state, bus outputs and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_period       <= DEFAULT_PERIOD;
      r_tick_count   <= 32'd0;
      r_snapshot     <= 32'd0;
      r_snap_lo      <= 16'd0;
      r_writedata    <= 16'd0;
      r_address      <= 3'd0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_busy         <= 1'b0;
      r_tick         <= 1'b0;
      r_snap_valid   <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      // Pulses last a single cycle unless re-armed below
      r_tick       <= 1'b0;
      r_snap_valid <= 1'b0;

      // Remember a stop seen while busy; cleared again when WR_STOP is entered
      if (r_state != S_IDLE && stop) begin
        r_stop_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_period     <= w_start_period;
            r_tick_count <= 32'd0;
            r_busy       <= 1'b1;
            r_write      <= 1'b1;
            r_address    <= ADDR_PERIOD_L;
            r_writedata  <= w_start_period[15:0];
            r_state      <= S_WR_PL;
          end
        end

        S_WR_PL: begin
          if (w_xfer_done) begin
            r_address   <= ADDR_PERIOD_H;
            r_writedata <= r_period[31:16];
            r_state     <= S_WR_PH;
          end
        end

        S_WR_PH: begin
          if (w_xfer_done) begin
            r_address   <= ADDR_CONTROL;
            r_writedata <= CTRL_RUN;
            r_state     <= S_WR_CTRL;
          end
        end

        S_WR_CTRL: begin
          if (w_xfer_done) begin
            r_write <= 1'b0;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Stop beats a timeout, a timeout beats a snapshot request
          if (w_stop_req) begin
            r_stop_pending <= 1'b0;
            r_write        <= 1'b1;
            r_address      <= ADDR_CONTROL;
            r_writedata    <= CTRL_STOP;
            r_state        <= S_WR_STOP;
          end else if (irq_in) begin
            r_write     <= 1'b1;
            r_address   <= ADDR_STATUS;
            r_writedata <= WORD_ZERO;
            r_state     <= S_ACK;
          end else if (snap_req) begin
            r_write     <= 1'b1;
            r_address   <= ADDR_SNAP_L;
            r_writedata <= WORD_ZERO;
            r_state     <= S_SNAP_WR;
          end
        end

        S_ACK: begin
          if (w_xfer_done) begin
            r_write      <= 1'b0;
            r_tick       <= 1'b1;
            r_tick_count <= r_tick_count + 32'd1;
            r_state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          // One dead cycle so the slave can drop its level interrupt
          r_state <= S_RUN;
        end

        S_SNAP_WR: begin
          if (w_xfer_done) begin
            r_write   <= 1'b0;
            r_read    <= 1'b1;
            r_address <= ADDR_SNAP_L;
            r_state   <= S_RD_SL;
          end
        end

        S_RD_SL: begin
          if (w_xfer_done) begin
            r_snap_lo <= avm_readdata;
            r_address <= ADDR_SNAP_H;
            r_state   <= S_RD_SH;
          end
        end

        S_RD_SH: begin
          if (w_xfer_done) begin
            r_read       <= 1'b0;
            r_snapshot   <= {avm_readdata, r_snap_lo};
            r_snap_valid <= 1'b1;
            r_state      <= S_RUN;
          end
        end

        S_WR_STOP: begin
          if (w_xfer_done) begin
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign avm_address   = r_address;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_writedata;
  assign busy          = r_busy;
  assign tick          = r_tick;
  assign tick_count    = r_tick_count;
  assign snapshot      = r_snapshot;
  assign snap_valid    = r_snap_valid;

endmodule

// File: tb/tb_lab3_qs_timer_ctrl.sv
// tb_lab3_qs_timer_ctrl
// Randomised bench: a slave model answers the master with random
// waitrequest, logs every completed transfer, and each scenario task compares
// the log and the status outputs against sequences derived from the rules.
`timescale 1ns/1ps
module tb_lab3_qs_timer_ctrl;

  localparam logic [31:0] DEF_P = 32'd49999999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        snap_req = 1'b0;
  logic        irq_in = 1'b0;
  logic [31:0] period_in = 32'd0;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'd0;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        tick;
  logic [31:0] tick_count;
  logic [31:0] snapshot;
  logic        snap_valid;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } xfer_t;

  xfer_t       log_q[$];
  int          log_cyc[$];
  int          cyc = 0;
  bit          rand_wait = 1'b0;
  int          stall3_left = 0;
  int          a3_cycles = 0;
  logic [15:0] slave_lo = 16'd0;
  logic [15:0] slave_hi = 16'd0;
  logic [31:0] m_tick_count = 32'd0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_bus = 21'd0;

  lab3_qs_timer_ctrl #(.DEFAULT_PERIOD(DEF_P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .snap_req(snap_req), .period_in(period_in), .irq_in(irq_in),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .tick(tick),
    .tick_count(tick_count), .snapshot(snapshot), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  // Slave model: decides waitrequest for the coming edge, checks bus rules,
  // records each transfer that completes at that edge
  always @(negedge clk) begin
    logic wr;
    cyc++;
    wr = 1'b0;
    if (!reset_n) begin
      prev_stall = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      checks++;
      if (avm_read && avm_write) begin
        failures++;
        $display("FAIL rw_exclusive: read=%0b write=%0b required not both", avm_read, avm_write);
      end
      if (prev_stall) begin
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata} !== prev_bus) begin
          failures++;
          $display("FAIL hold_stable: bus=%h required %h", {avm_read, avm_write, avm_address, avm_writedata}, prev_bus);
        end
      end
      if (!busy && (avm_read || avm_write)) begin
        failures++;
        $display("FAIL idle_bus: read=%0b write=%0b with busy=0 required both 0", avm_read, avm_write);
      end
      if (avm_read || avm_write) begin
        if (avm_write && avm_address == 3'd3) a3_cycles++;
        if (stall3_left > 0 && avm_write && avm_address == 3'd3) begin
          wr = 1'b1;
          stall3_left--;
        end else if (rand_wait) begin
          wr = ($urandom_range(0, 2) == 0);
        end
        if (wr) begin
          avm_readdata = 16'($urandom);
        end else begin
          if (avm_read)
            avm_readdata = (avm_address == 3'd4) ? slave_lo :
                           (avm_address == 3'd5) ? slave_hi : 16'hDEAD;
          log_q.push_back(xfer_t'({avm_write, avm_address, avm_write ? avm_writedata : avm_readdata}));
          log_cyc.push_back(cyc);
        end
      end
      prev_stall = wr && (avm_read || avm_write);
      prev_bus = {avm_read, avm_write, avm_address, avm_writedata};
      avm_waitrequest = wr;
    end
  end

  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p == 32'd0) ? DEF_P : p;
  endfunction

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic pulse_start(input logic [31:0] p);
    @(negedge clk); start = 1'b1; period_in = p;
    @(negedge clk); start = 1'b0; period_in = $urandom;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (log_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, tick, snap_valid, avm_read, avm_write, avm_address, avm_writedata, tick_count, snapshot} !== 88'd0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", {busy, tick, snap_valid, avm_read, avm_write, avm_address, avm_writedata, tick_count, snapshot});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, avm_read, avm_write, tick_count} !== 35'd0) begin
      failures++;
      $display("FAIL after_reset: got %h required 0", {busy, avm_read, avm_write, tick_count});
    end
  endtask

  task automatic test_start_patterns();
    logic [31:0] pats [4];
    logic [31:0] pe;
    xfer_t       exp_q[$];
    bit          ok;
    int          gap;
    pats[0] = 32'h0001_0003;
    pats[1] = 32'd0;
    pats[2] = $urandom;
    pats[3] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      rand_wait = (k >= 2);
      pe = eff_period(pats[k]);
      exp_q.delete();
      exp_q.push_back(xfer_t'({1'b1, 3'd2, pe[15:0]}));
      exp_q.push_back(xfer_t'({1'b1, 3'd3, pe[31:16]}));
      exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0007}));
      exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0008}));
      clear_log();
      pulse_start(pats[k]);
      wait_log(3, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL start_timeout[%0d]: got %0d transfers required 3", k, log_q.size()); end
      if (!rand_wait) begin
        gap = ok ? (log_cyc[2] - log_cyc[0]) : -1;
        checks++;
        if (gap != 2) begin failures++; $display("FAIL start_consecutive[%0d]: got span %0d required 2", k, gap); end
      end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL start_busy[%0d]: got %0b required 1", k, busy); end
      repeat (2) @(negedge clk);
      pulse_stop();
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL start_stop_idle[%0d]: got busy=%0b required 0", k, busy); end
      checks++;
      if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL start_log_len[%0d]: got %0d required %0d", k, log_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL start_log[%0d][%0d]: got %h required %h", k, i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_waitreq();
    logic [31:0] p;
    xfer_t       exp_q[$];
    bit          ok;
    p = $urandom | 32'd1;
    rand_wait = 1'b0;
    stall3_left = 3;
    a3_cycles = 0;
    exp_q.push_back(xfer_t'({1'b1, 3'd2, p[15:0]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd3, p[31:16]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0007}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0008}));
    clear_log();
    pulse_start(p);
    wait_log(3, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (a3_cycles != 4) begin failures++; $display("FAIL wait_addr3_cycles: got %0d required 4", a3_cycles); end
    pulse_stop();
    wait_idle(ok);
    checks++;
    if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL wait_log_len: got %0d required %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL wait_log[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] p;
    logic [31:0] pe;
    xfer_t       exp_q[$];
    bit          ok;
    bit          got;
    p = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
    pe = eff_period(p);
    rand_wait = 1'b1;
    exp_q.push_back(xfer_t'({1'b1, 3'd2, pe[15:0]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd3, pe[31:16]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0007}));
    clear_log();
    pulse_start(p);
    m_tick_count = 32'd0;
    wait_log(3, ok);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      irq_in = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (tick === 1'b1) begin got = 1'b1; break; end
      end
      irq_in = 1'b0;
      m_tick_count = m_tick_count + 32'd1;
      exp_q.push_back(xfer_t'({1'b1, 3'd0, 16'h0000}));
      checks++;
      if (!got || tick_count !== m_tick_count) begin failures++; $display("FAIL irq_tick[%0d]: got tick=%0b count=%h required tick=1 count=%h", k, got, tick_count, m_tick_count); end
      @(negedge clk);
      checks++;
      if (tick !== 1'b0) begin failures++; $display("FAIL irq_tick_width[%0d]: got %0b required 0", k, tick); end
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL irq_log_len: got %0d required %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL irq_log[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    bit got;
    @(negedge clk);
    force dut.r_tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_tick_count;
    m_tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (tick_count !== m_tick_count) begin failures++; $display("FAIL wrap_preload: got %h required %h", tick_count, m_tick_count); end
    for (int k = 0; k < 2; k++) begin
      irq_in = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (tick === 1'b1) begin got = 1'b1; break; end
      end
      irq_in = 1'b0;
      m_tick_count = m_tick_count + 32'd1;
      checks++;
      if (!got || tick_count !== m_tick_count) begin failures++; $display("FAIL wrap_tick[%0d]: got tick=%0b count=%h required tick=1 count=%h", k, got, tick_count, m_tick_count); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_snapshot();
    xfer_t exp_q[$];
    bit    got;
    clear_log();
    rand_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      slave_lo = (k == 0) ? 16'h1234 : 16'($urandom);
      slave_hi = (k == 0) ? 16'h0ABC : 16'($urandom);
      exp_q.push_back(xfer_t'({1'b1, 3'd4, 16'h0000}));
      exp_q.push_back(xfer_t'({1'b0, 3'd4, slave_lo}));
      exp_q.push_back(xfer_t'({1'b0, 3'd5, slave_hi}));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (snap_valid === 1'b1) begin got = 1'b1; break; end
        @(negedge clk);
      end
      checks++;
      if (!got || snapshot !== {slave_hi, slave_lo}) begin failures++; $display("FAIL snap_value[%0d]: got valid=%0b value=%h required valid=1 value=%h", k, got, snapshot, {slave_hi, slave_lo}); end
      @(negedge clk);
      checks++;
      if (snap_valid !== 1'b0) begin failures++; $display("FAIL snap_valid_width[%0d]: got %0b required 0", k, snap_valid); end
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL snap_log_len: got %0d required %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL snap_log[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stop_irq_same();
    int ticks;
    bit ok;
    clear_log();
    @(negedge clk);
    stop = 1'b1;
    irq_in = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    ticks = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (tick === 1'b1) ticks++;
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    irq_in = 1'b0;
    checks++;
    if (!ok || ticks != 0 || tick_count !== m_tick_count) begin failures++; $display("FAIL stop_irq: got idle=%0b ticks=%0d count=%h required idle=1 ticks=0 count=%h", ok, ticks, tick_count, m_tick_count); end
    checks++;
    if (log_q.size() != 1 || log_q[0] !== xfer_t'({1'b1, 3'd1, 16'h0008})) begin failures++; $display("FAIL stop_irq_log: got %0d transfers first=%h required 1 of %h", log_q.size(), (log_q.size() > 0) ? log_q[0] : 20'd0, {1'b1, 3'd1, 16'h0008}); end
  endtask

  task automatic test_ignored_idle();
    logic [31:0] p;
    xfer_t       exp_q[$];
    bit          ok;
    clear_log();
    @(negedge clk);
    stop = 1'b1; snap_req = 1'b1; irq_in = 1'b1;
    @(negedge clk);
    stop = 1'b0; snap_req = 1'b0;
    repeat (3) @(negedge clk);
    irq_in = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_q.size() != 0 || tick_count !== m_tick_count) begin failures++; $display("FAIL idle_ignore: got busy=%0b transfers=%0d count=%h required 0 0 %h", busy, log_q.size(), tick_count, m_tick_count); end
    p = $urandom | 32'h0000_0100;
    exp_q.push_back(xfer_t'({1'b1, 3'd2, p[15:0]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd3, p[31:16]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0007}));
    pulse_start(p);
    m_tick_count = 32'd0;
    checks++;
    if (tick_count !== m_tick_count) begin failures++; $display("FAIL start_clears_count: got %h required %h", tick_count, m_tick_count); end
    wait_log(3, ok);
    repeat (3) @(negedge clk);
    pulse_start(~p);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL idle_stop_not_held: got busy=%0b required 1", busy); end
    checks++;
    if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL ignore_log_len: got %0d required %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL ignore_log[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    pulse_stop();
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ignore_stop_idle: got busy=%0b required 0", busy); end
  endtask

  task automatic test_stop_during_wrpl();
    logic [31:0] p;
    xfer_t       exp_q[$];
    bit          ok;
    p = $urandom;
    rand_wait = 1'b1;
    exp_q.push_back(xfer_t'({1'b1, 3'd2, p[15:0]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd3, p[31:16]}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0007}));
    exp_q.push_back(xfer_t'({1'b1, 3'd1, 16'h0008}));
    clear_log();
    @(negedge clk); start = 1'b1; period_in = p;
    @(negedge clk); start = 1'b0; stop = 1'b1; snap_req = 1'b1;
    @(negedge clk); stop = 1'b0; snap_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin failures++; $display("FAIL wrpl_stop_idle: got busy=%0b required 0", busy); end
    checks++;
    if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL wrpl_log_len: got %0d required %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrpl_log[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    rand_wait = 1'b0;
    stall3_left = 1000;
    a3_cycles = 0;
    clear_log();
    pulse_start($urandom);
    for (int c = 0; c < 50; c++) begin
      if (a3_cycles >= 2) break;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, tick, snap_valid, avm_read, avm_write, avm_address, avm_writedata, tick_count, snapshot} !== 88'd0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h required 0", {busy, tick, snap_valid, avm_read, avm_write, avm_address, avm_writedata, tick_count, snapshot});
    end
    repeat (2) @(negedge clk);
    stall3_left = 0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_q.size() != 1) begin failures++; $display("FAIL reset_mid_abandon: got busy=%0b transfers=%0d required 0 1", busy, log_q.size()); end
  endtask

  initial begin
    test_reset();
    test_start_patterns();
    test_waitreq();
    test_irq();
    test_wrap();
    test_snapshot();
    test_stop_irq_same();
    test_ignored_idle();
    test_stop_during_wrpl();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
